// File: rtl/block_mem_pkg.sv
// block_mem_pkg: shared constants, address field slices, FSM state type and
// backing-store initialiser for the block memory responder.
//   No ports.
package block_mem_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ADDR_W          = 10;
  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned MEM_WORDS       = 256;

  // Byte-address field slices: block = addr[9:4], word offset = addr[3:2].
  localparam int unsigned BLOCK_MSB = 9;
  localparam int unsigned BLOCK_LSB = 4;
  localparam int unsigned WORD_MSB  = 3;
  localparam int unsigned WORD_LSB  = 2;

  localparam int unsigned BLOCK_W = BLOCK_MSB - BLOCK_LSB + 1;
  localparam int unsigned BEAT_W  = WORD_MSB - WORD_LSB + 1;
  localparam int unsigned IDX_W   = BLOCK_W + BEAT_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_BURST,
    ST_WR_BURST,
    ST_WR_WAIT
  } state_e;

  typedef logic [MEM_WORDS-1:0][DATA_W-1:0] mem_t;

  // Power-up image: every word holds its own index, zero-extended.
  function automatic mem_t mem_init();
    mem_t m;
    for (int unsigned i = 0; i < MEM_WORDS; i++) begin
      m[i] = DATA_W'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/block_mem_array.sv
// block_mem_array: MEM_WORDS x DATA_W backing store, loaded with
// memory[i] = i at time 0 and never cleared by reset.
//   clk_i    clock, rising edge
//   we_i     write enable
//   waddr_i  write word index
//   wdata_i  write data
//   raddr_i  read word index (combinational read)
//   rdata_o  read data
module block_mem_array
  import block_mem_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  mem_t memory = mem_init();

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      memory[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = memory[raddr_i];

endmodule

// File: rtl/block_mem_responder.sv
// block_mem_responder: memory-side end of the cache refill / write-back
// protocol. Accepts one 4-word block request at a time, waits
// ACCESS_LATENCY cycles, then streams a read burst or absorbs a write burst
// (write completion is signalled ACCESS_LATENCY cycles after the last beat).
// Optional build macro BLOCK_MEM_CRIT_WORD_FIRST_EN: read bursts start at the
// requested word and wrap within the block.
//   clk, rst                 clock / synchronous active-high reset
//   req_valid/req_ready      request handshake (req_write, req_addr)
//   wdata_valid/wdata_ready  write beat handshake (wdata)
//   rdata_valid/rdata/rdata_last  read beats, no backpressure
//   resp_done                one-cycle transaction-complete pulse
module block_mem_responder
  import block_mem_pkg::*;
#(
  parameter int unsigned ACCESS_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              resp_done
);

  if (ACCESS_LATENCY < 1) begin : g_latency_check
    $error("block_mem_responder: ACCESS_LATENCY must be >= 1");
  end

  localparam int unsigned LAT_W = $clog2(ACCESS_LATENCY + 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(ACCESS_LATENCY - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(WORDS_PER_BLOCK - 1);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [BLOCK_W-1:0]  block_q, block_d;
  logic                mem_we;
  logic [IDX_W-1:0]    mem_raddr;
  logic [DATA_W-1:0]   mem_rdata;

`ifdef BLOCK_MEM_CRIT_WORD_FIRST_EN
  logic [BEAT_W-1:0]   offset_q, offset_d;
  logic                unused_addr;
  assign unused_addr = ^req_addr[WORD_LSB-1:0];
  // BEAT_W-bit add wraps modulo the block size.
  assign mem_raddr = {block_q, offset_q + beat_q};
`else
  logic                unused_addr;
  assign unused_addr = ^{req_addr[WORD_MSB:0]};
  assign mem_raddr = {block_q, beat_q};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      lat_q    <= '0;
      block_q  <= '0;
`ifdef BLOCK_MEM_CRIT_WORD_FIRST_EN
      offset_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      block_q  <= block_d;
`ifdef BLOCK_MEM_CRIT_WORD_FIRST_EN
      offset_q <= offset_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    lat_d       = lat_q;
    block_d     = block_q;
`ifdef BLOCK_MEM_CRIT_WORD_FIRST_EN
    offset_d    = offset_q;
`endif
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    rdata_valid = 1'b0;
    rdata       = '0;
    rdata_last  = 1'b0;
    resp_done   = 1'b0;
    mem_we      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          block_d  = req_addr[BLOCK_MSB:BLOCK_LSB];
`ifdef BLOCK_MEM_CRIT_WORD_FIRST_EN
          offset_d = req_addr[WORD_MSB:WORD_LSB];
`endif
          beat_d   = '0;
          lat_d    = '0;
          state_d  = req_write ? ST_WR_BURST : ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = ST_RD_BURST;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      ST_RD_BURST: begin
        rdata_valid = 1'b1;
        rdata       = mem_rdata;
        beat_d      = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_LAST) begin
          rdata_last = 1'b1;
          resp_done  = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_WR_BURST: begin
        wdata_ready = 1'b1;
        if (wdata_valid) begin
          // Suppressed under reset so an abort never commits a further beat.
          mem_we = !rst;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_LAST) begin
            state_d = ST_WR_WAIT;
          end
        end
      end
      ST_WR_WAIT: begin
        if (lat_q == LAT_LAST) begin
          resp_done = 1'b1;
          lat_d     = '0;
          state_d   = ST_IDLE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  block_mem_array u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i ({block_q, beat_q}),
    .wdata_i (wdata),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

endmodule
